// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative multiply/divide unit that owns the HI/LO register pair.
// A shift-add multiplier and a restoring divider share one working register
// pair and retire one bit per clock, so MULT/MULTU/DIV/DIVU take WIDTH cycles.
// MTHI/MTLO and divide-by-zero finish on the accept edge.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   start     request, accepted on a rising edge while busy = 0
//   op        000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//             110/111 no-op
//   src_a     multiplicand / dividend / MTHI-MTLO data
//   src_b     multiplier / divisor
//   hi        HI register: product upper half or remainder
//   lo        LO register: product lower half or quotient
//   busy      iterative op in progress
//   done      one-cycle pulse when an accepted op commits
//   div_zero  one-cycle pulse when DIV/DIVU is issued with src_b = 0
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; MTHI/MTLO/div-by-zero complete here
// S_MUL  | shift-add multiply, one multiplier bit per cycle
// S_DIV  | restoring divide, one quotient bit per cycle

module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    // MUL: work_hi = partial sum, work_lo = remaining multiplier bits / product low
    // DIV: work_hi = partial remainder, work_lo = dividend shifting out / quotient in
    logic [WIDTH-1:0]   work_hi, work_hi_n;
    logic [WIDTH-1:0]   work_lo, work_lo_n;
    logic [WIDTH-1:0]   opnd, opnd_n;
    logic               neg_res, neg_res_n;
    logic               neg_rem, neg_rem_n;
    logic [WIDTH-1:0]   hi_n, lo_n;
    logic               busy_n, done_n, div_zero_n;

    logic               is_signed;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_n, mul_lo_n;
    logic [2*WIDTH-1:0] prod, prod_fix;

    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_hi_n, div_lo_n;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Operand magnitudes; the most-negative value maps onto itself, which is
    // the correct unsigned magnitude 2^(WIDTH-1).
    always_comb begin
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        sign_a    = is_signed & src_a[WIDTH-1];
        sign_b    = is_signed & src_b[WIDTH-1];
        mag_a     = sign_a ? -src_a : src_a;
        mag_b     = sign_b ? -src_b : src_b;
    end

    // One multiply step: conditionally add, then shift the 2W-bit pair right.
    always_comb begin
        mul_sum  = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);
        mul_hi_n = mul_sum[WIDTH:1];
        mul_lo_n = {mul_sum[0], work_lo[WIDTH-1:1]};
        prod     = {mul_hi_n, mul_lo_n};
        prod_fix = neg_res ? -prod : prod;
    end

    // One restoring divide step. The shifted remainder needs WIDTH+1 bits
    // because the divisor may use the full WIDTH.
    always_comb begin
        div_shift = {work_hi, work_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_hi_n  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_lo_n  = {work_lo[WIDTH-2:0], div_ge};
        quo_fix   = neg_res ? -div_lo_n : div_lo_n;
        rem_fix   = neg_rem ? -div_hi_n : div_hi_n;
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        work_hi_n  = work_hi;
        work_lo_n  = work_lo;
        opnd_n     = opnd;
        neg_res_n  = neg_res;
        neg_rem_n  = neg_rem;
        hi_n       = hi;
        lo_n       = lo;
        done_n     = 1'b0;
        div_zero_n = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            state_n   = S_MUL;
                            cnt_n     = CNT_W'(WIDTH);
                            work_hi_n = '0;
                            work_lo_n = mag_b;
                            opnd_n    = mag_a;
                            neg_res_n = sign_a ^ sign_b;
                            neg_rem_n = 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (src_b == '0) begin
                                done_n     = 1'b1;
                                div_zero_n = 1'b1;
                            end else begin
                                state_n   = S_DIV;
                                cnt_n     = CNT_W'(WIDTH);
                                work_hi_n = '0;
                                work_lo_n = mag_a;
                                opnd_n    = mag_b;
                                neg_res_n = sign_a ^ sign_b;
                                neg_rem_n = sign_a;
                            end
                        end
                        OP_MTHI: begin
                            hi_n   = src_a;
                            done_n = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_n   = src_a;
                            done_n = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                work_hi_n = mul_hi_n;
                work_lo_n = mul_lo_n;
                cnt_n     = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    hi_n    = prod_fix[2*WIDTH-1:WIDTH];
                    lo_n    = prod_fix[WIDTH-1:0];
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_DIV: begin
                work_hi_n = div_hi_n;
                work_lo_n = div_lo_n;
                cnt_n     = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    hi_n    = rem_fix;
                    lo_n    = quo_fix;
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            work_hi  <= '0;
            work_lo  <= '0;
            opnd     <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            work_hi  <= work_hi_n;
            work_lo  <= work_lo_n;
            opnd     <= opnd_n;
            neg_res  <= neg_res_n;
            neg_rem  <= neg_rem_n;
            hi       <= hi_n;
            lo       <= lo_n;
            busy     <= busy_n;
            done     <= done_n;
            div_zero <= div_zero_n;
        end
    end

endmodule
